// File: rtl/life_hud_drawer.sv
// life_hud_drawer
//   Lives indicator for the VGA HUD. Each life is a solid ICON_W x ICON_H
//   rectangle in a vertical column of MAX_LIVES slots. After reset the block
//   paints every slot once. It then waits for lose/gain requests and repaints
//   one slot per accepted request, one pixel per enabled cycle. When the last
//   life has been erased it parks in a sticky game-over state.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, restarts the initial paint
//   enable       cycle enable; when low all state and outputs hold
//   lose_a_life  single-cycle request to remove one life (sampled only when idle)
//   gain_a_life  single-cycle request to add one life (sampled only when idle)
//   active       high while this block owns the pixel write port
//   game_over    sticky, all lives gone
//   lives        current live count
//   x_out/y_out  pixel coordinate
//   colour_out   pixel colour
//   write_out    pixel on x_out/y_out/colour_out is valid this cycle
module life_hud_drawer #(
  parameter int          MAX_LIVES   = 3,
  parameter int          START_LIVES = 3,
  parameter int          ICON_W      = 4,
  parameter int          ICON_H      = 4,
  parameter int          ICON_PITCH  = 4,
  parameter int          X0          = 146,
  parameter int          Y0          = 87,
  parameter logic [2:0]  COLOUR_ON   = 3'b111,
  parameter logic [2:0]  COLOUR_OFF  = 3'b000,
  localparam int         CW          = $clog2(MAX_LIVES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          lose_a_life,
  input  logic          gain_a_life,
  output logic          active,
  output logic          game_over,
  output logic [CW-1:0] lives,
  output logic [7:0]    x_out,
  output logic [6:0]    y_out,
  output logic [2:0]    colour_out,
  output logic          write_out
);

  localparam logic [7:0]    PX_LAST   = 8'(ICON_W - 1);
  localparam logic [6:0]    PY_LAST   = 7'(ICON_H - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(MAX_LIVES - 1);
  localparam logic [CW-1:0] MAX_L     = CW'(MAX_LIVES);
  localparam logic [CW-1:0] START_L   = CW'(START_LIVES);
  localparam logic [CW-1:0] ONE_L     = CW'(1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_DRAW,
    S_OVER
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] lives_q, lives_n;
  logic [CW-1:0] slot_q, slot_n;
  logic [7:0]    px_q, px_n;
  logic [6:0]    py_q, py_n;
  logic [2:0]    colour_q, colour_n;
  logic          gain_pend_q, gain_pend_n;
  logic          slot_done;
  logic [CW-1:0] lives_end;

  assign slot_done = (px_q == PX_LAST) && (py_q == PY_LAST);

  // A gain only bumps the count once its icon is fully painted.
  assign lives_end = gain_pend_q ? (lives_q + ONE_L) : lives_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      lives_q     <= START_L;
      slot_q      <= '0;
      px_q        <= '0;
      py_q        <= '0;
      colour_q    <= COLOUR_ON;
      gain_pend_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      lives_q     <= lives_n;
      slot_q      <= slot_n;
      px_q        <= px_n;
      py_q        <= py_n;
      colour_q    <= colour_n;
      gain_pend_q <= gain_pend_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    lives_n     = lives_q;
    slot_n      = slot_q;
    px_n        = px_q;
    py_n        = py_q;
    colour_n    = colour_q;
    gain_pend_n = gain_pend_q;

    if (enable) begin
      unique case (state_q)
        S_INIT, S_DRAW: begin
          // Raster walk inside the slot: x first, then y.
          if (px_q == PX_LAST) begin
            px_n = '0;
            if (py_q == PY_LAST) begin
              py_n = '0;
            end else begin
              py_n = py_q + 7'd1;
            end
          end else begin
            px_n = px_q + 8'd1;
          end

          if (slot_done) begin
            if (state_q == S_INIT) begin
              if (slot_q == SLOT_LAST) begin
                state_n = S_IDLE;
              end else begin
                slot_n = slot_q + ONE_L;
              end
            end else begin
              lives_n     = lives_end;
              gain_pend_n = 1'b0;
              state_n     = (lives_end == '0) ? S_OVER : S_IDLE;
            end
          end
        end

        S_IDLE: begin
          // Simultaneous lose and gain cancel out; lives is always >= 1 here.
          if (lose_a_life && !gain_a_life) begin
            lives_n  = lives_q - ONE_L;
            slot_n   = lives_q - ONE_L;
            colour_n = COLOUR_OFF;
            px_n     = '0;
            py_n     = '0;
            state_n  = S_DRAW;
          end else if (gain_a_life && !lose_a_life && (lives_q < MAX_L)) begin
            slot_n      = lives_q;
            colour_n    = COLOUR_ON;
            gain_pend_n = 1'b1;
            px_n        = '0;
            py_n        = '0;
            state_n     = S_DRAW;
          end
        end

        S_OVER: begin
        end

        default: begin
          state_n = S_INIT;
        end
      endcase
    end
  end

  assign active    = (state_q == S_INIT) || (state_q == S_DRAW);
  assign write_out = active;
  assign game_over = (state_q == S_OVER);
  assign lives     = lives_q;

  // The initial paint colours each slot from START_LIVES; redraws use the latched colour.
  assign colour_out = (state_q == S_INIT) ? ((slot_q < START_L) ? COLOUR_ON : COLOUR_OFF)
                                          : colour_q;

  // Coordinates are formed at integer width and truncated to the port width.
  assign x_out = 8'(X0 + int'(px_q));
  assign y_out = 7'(Y0 + int'(slot_q) * ICON_PITCH + int'(py_q));

endmodule

// File: tb/tb_life_hud_drawer.sv
// tb_life_hud_drawer
//   Self-checking bench for life_hud_drawer with default parameters.
//   Expected pixels are queued whenever a draw is provoked and compared as the
//   DUT presents them; counters and status flags are checked at key edges.
module tb_life_hud_drawer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       lose_a_life;
  logic       gain_a_life;
  logic       active;
  logic       game_over;
  logic [1:0] lives;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       write_out;

  int assertionCount = 0;
  int failCount      = 0;

  // Expected pixel stream: {x, y, colour}
  logic [17:0] sb[$];

  life_hud_drawer dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lose_a_life(lose_a_life),
    .gain_a_life(gain_a_life),
    .active     (active),
    .game_over  (game_over),
    .lives      (lives),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .write_out  (write_out)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertionCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Queue the first 'count' raster pixels of slot k in colour c
  task automatic pushSlot(input int k, input logic [2:0] c, input int count);
    for (int i = 0; i < count; i++) begin
      sb.push_back({8'(146 + (i % 4)), 7'(87 + k * 4 + (i / 4)), c});
    end
  endtask

  task automatic pushInit();
    for (int k = 0; k < 3; k++) pushSlot(k, 3'b111, 16);
  endtask

  // One-cycle request pulse; called and returns at #1 after a rising edge
  task automatic applyStimulus(input logic lose, input logic gain);
    lose_a_life = lose;
    gain_a_life = gain;
    @(posedge clk);
    #1;
    lose_a_life = 1'b0;
    gain_a_life = 1'b0;
  endtask

  // Counts edges until active drops, bounded
  task automatic countToIdle(output int n);
    n = 0;
    while (active && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("idle_reached", {31'd0, active}, 32'd0);
  endtask

  task automatic checkResetState();
    checkOutput("rst_lives", {30'd0, lives}, 32'd3);
    checkOutput("rst_x", {24'd0, x_out}, 32'd146);
    checkOutput("rst_y", {25'd0, y_out}, 32'd87);
    checkOutput("rst_colour", {29'd0, colour_out}, 32'd7);
    checkOutput("rst_write", {31'd0, write_out}, 32'd1);
    checkOutput("rst_active", {31'd0, active}, 32'd1);
    checkOutput("rst_game_over", {31'd0, game_over}, 32'd0);
  endtask

  // Pixel monitor: a pixel is consumed on each enabled, non-reset edge it is shown for
  always @(negedge clk) begin
    if (!reset && enable && write_out) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", {14'd0, x_out, y_out, colour_out}, 32'd0);
      end else begin
        checkOutput("pixel", {14'd0, x_out, y_out, colour_out}, {14'd0, sb.pop_front()});
      end
    end
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] xHold;
    logic [6:0] yHold;

    reset       = 1'b1;
    enable      = 1'b1;
    lose_a_life = 1'b0;
    gain_a_life = 1'b0;

    // Reset and initial paint of three lit icons
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    pushInit();
    reset = 1'b0;
    countToIdle(n);
    checkOutput("init_cycles", n, 48);
    checkOutput("init_lives", {30'd0, lives}, 32'd3);
    checkOutput("init_sb_empty", sb.size(), 0);

    // Loss from 3: lives drops at the accepting edge, slot 2 erased
    pushSlot(2, 3'b000, 16);
    applyStimulus(1'b1, 1'b0);
    checkOutput("loss_lives_now", {30'd0, lives}, 32'd2);
    checkOutput("loss_active", {31'd0, active}, 32'd1);
    countToIdle(n);
    checkOutput("loss_cycles", n, 16);
    checkOutput("loss_game_over", {31'd0, game_over}, 32'd0);
    checkOutput("loss_sb_empty", sb.size(), 0);

    // Gain from 2: lives increments only at the end edge
    pushSlot(2, 3'b111, 16);
    applyStimulus(1'b0, 1'b1);
    checkOutput("gain_lives_now", {30'd0, lives}, 32'd2);
    countToIdle(n);
    checkOutput("gain_cycles", n, 16);
    checkOutput("gain_lives_end", {30'd0, lives}, 32'd3);

    // Gain at maximum is a no-op
    applyStimulus(1'b0, 1'b1);
    checkOutput("gain_sat_active", {31'd0, active}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("gain_sat_lives", {30'd0, lives}, 32'd3);

    // Lose and gain together cancel
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_active", {31'd0, active}, 32'd0);
    checkOutput("both_lives", {30'd0, lives}, 32'd3);

    // A loss request during a draw is dropped
    pushSlot(2, 3'b000, 16);
    applyStimulus(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0);
    countToIdle(n);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drop_lives", {30'd0, lives}, 32'd2);
    checkOutput("drop_active", {31'd0, active}, 32'd0);
    checkOutput("drop_sb_empty", sb.size(), 0);

    // Back to 3, then three spaced losses down to game over
    pushSlot(2, 3'b111, 16);
    applyStimulus(1'b0, 1'b1);
    countToIdle(n);
    checkOutput("regain_lives", {30'd0, lives}, 32'd3);
    for (int k = 2; k >= 0; k--) begin
      pushSlot(k, 3'b000, 16);
      applyStimulus(1'b1, 1'b0);
      checkOutput("spaced_loss_lives", {30'd0, lives}, 32'(k));
      countToIdle(n);
      checkOutput("spaced_loss_cycles", n, 16);
      checkOutput("spaced_game_over", {31'd0, game_over}, (k == 0) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("over_sb_empty", sb.size(), 0);

    // Requests in game over are ignored
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("over_lives", {30'd0, lives}, 32'd0);
    checkOutput("over_active", {31'd0, active}, 32'd0);
    checkOutput("over_sticky", {31'd0, game_over}, 32'd1);

    // Reset out of game over restarts the initial paint
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState();
    pushInit();
    reset = 1'b0;
    countToIdle(n);
    checkOutput("reinit_cycles", n, 48);

    // Erase with a 5-cycle enable stall in the middle
    pushSlot(2, 3'b000, 16);
    applyStimulus(1'b1, 1'b0);
    n = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      n++;
    end
    xHold  = x_out;
    yHold  = y_out;
    enable = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("stall_x", {24'd0, x_out}, {24'd0, xHold});
    checkOutput("stall_y", {25'd0, y_out}, {25'd0, yHold});
    checkOutput("stall_x_pos", {24'd0, x_out}, 32'd148);
    checkOutput("stall_write", {31'd0, write_out}, 32'd1);
    enable = 1'b1;
    while (active && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("stall_cycles", n, 21);
    checkOutput("stall_lives", {30'd0, lives}, 32'd2);
    checkOutput("stall_sb_empty", sb.size(), 0);

    // Reset in the middle of an erase
    pushSlot(1, 3'b000, 5);
    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_lives", {30'd0, lives}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkResetState();
    checkOutput("mid_sb_empty", sb.size(), 0);
    pushInit();
    reset = 1'b0;
    countToIdle(n);
    checkOutput("final_lives", {30'd0, lives}, 32'd3);
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
    $finish;
  end

endmodule

// File: doc/life_hud_drawer.md
# life_hud_drawer

Parametrised lives indicator for the VGA HUD. Each life is drawn as a solid rectangular icon in a vertical column of slots, one pixel per enabled cycle, into the shared pixel-write path. It supports both losing and gaining lives, exposes the live count, and raises `game_over` once the last icon has been erased. Its pixel outputs feed the frame-buffer write arbiter; `active` tells the arbiter that this block owns the write port.

## Interface
- `MAX_LIVES`, 3: number of icon slots; also the upper bound on the live count.
- `START_LIVES`, 3: live count after reset; legal range 1..`MAX_LIVES`.
- `ICON_W`, 4: icon width in pixels.
- `ICON_H`, 4: icon height in pixels.
- `ICON_PITCH`, 4: vertical distance between slot origins; must be ≥ `ICON_H`.
- `X0`, 146: x coordinate of every slot origin. `X0+ICON_W-1` must be ≤ 159.
- `Y0`, 87: y coordinate of the slot 0 origin. `Y0+(MAX_LIVES-1)*ICON_PITCH+ICON_H-1` must be ≤ 119.
- `COLOUR_ON`, 3'b111: colour used for a present life.
- `COLOUR_OFF`, 3'b000: colour used for an erased life.
- `CW`, derived as $clog2(`MAX_LIVES`+1): width of the `lives` output.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: cycle enable. When low, all state and outputs hold and events are ignored.
- `lose_a_life` in 1: single-cycle request to remove one life.
- `gain_a_life` in 1: single-cycle request to add one life.
- `active` out 1: block is drawing and owns the pixel port.
- `game_over` out 1: sticky; all lives are gone.
- `lives` out `CW`: current live count.
- `x_out` out 8: pixel x coordinate.
- `y_out` out 7: pixel y coordinate.
- `colour_out` out 3: pixel colour.
- `write_out` out 1: the pixel on `x_out`/`y_out`/`colour_out` is valid this cycle.

## Operation
**Slot geometry**
- Slot k covers x = `X0`..`X0+ICON_W-1` and y = `Y0+k*ICON_PITCH` .. that value +`ICON_H-1`.
- Raster order: x increments first, then y.

**States**
- INIT: draws all `MAX_LIVES` slots in order 0..`MAX_LIVES-1`.
  - Slot k uses `COLOUR_ON` if k < `START_LIVES`, otherwise `COLOUR_OFF`.
  - Goes to IDLE after the last pixel.
- IDLE: `write_out`=0 and `active`=0. With `enable`=1, requests are sampled here:
  - `lose_a_life` only: `lives` becomes `lives`-1. Go to DRAW on slot (new `lives`) with `COLOUR_OFF`.
  - `gain_a_life` only, with `lives` < `MAX_LIVES`: go to DRAW on slot (old `lives`) with `COLOUR_ON`, then `lives` becomes `lives`+1.
  - `gain_a_life` only, with `lives` = `MAX_LIVES`: no action.
  - Both asserted in the same cycle: they cancel; no action and no draw.
- DRAW: emits `ICON_W*ICON_H` pixels of one slot. At the end:
  - if `lives` = 0, go to OVER;
  - otherwise go to IDLE.
- OVER: `game_over`=1, `active`=0, `write_out`=0. All requests are ignored until `reset`.

**Request handling**
- Requests that arrive in INIT, DRAW or OVER are dropped, not queued. The issuing logic must wait for `active`=0.

**Counter arithmetic**
- `lives` never wraps below 0; a loss is only possible when `lives` ≥ 1, because reaching 0 forces OVER.
- `lives` saturates at `MAX_LIVES`.
- Pixel coordinates are computed at full width and truncated to 8/7 bits. Legal parameters never overflow.

## Timing
**Reset values** (after a reset edge):
- `lives`=`START_LIVES`, `x_out`=`X0`, `y_out`=`Y0`.
- `colour_out`=`COLOUR_ON`, `write_out`=1, `active`=1, `game_over`=0.
- State is INIT, presenting pixel 0 of slot 0.

**Pixel stepping**
- Each enabled edge in INIT or DRAW advances to the next pixel.
- The enabled edge that follows the final pixel drives `write_out`=0 and `active`=0, and drives `game_over`=1 when entering OVER.

**Durations** (with `enable` held high):
- INIT presents `MAX_LIVES*ICON_W*ICON_H` pixels. With defaults this is 48 cycles, ending at (149,98).
- For an event accepted at edge N:
  - edge N updates `lives` on a loss, loads the slot origin and colour, and sets `write_out`=1 and `active`=1;
  - `active` falls at edge N+`ICON_W*ICON_H` (N+16 with defaults);
  - on a gain, `lives` increments at that same end edge.
- IDLE-to-IDLE minimum spacing between accepted events is `ICON_W*ICON_H`+1 cycles.

**Stalls and reset**
- `enable`=0 mid-draw freezes the current pixel, with `write_out` held. Drawing resumes without skipping or repeating a pixel.
- `reset` mid-INIT, mid-DRAW or in OVER restarts INIT on the next edge, regardless of `enable`.

## Test plan
- Reset with defaults, `enable`=1 → 48 pixels of 3'b111 covering x146–149, y87–98 in raster order, then `active`=0, `lives`=3.
- From idle, `lose_a_life` pulse → `lives`=2 at the same edge, 16 pixels of 3'b000 at y95–98, `active` low 16 cycles later, `game_over`=0.
- At `lives`=2, `gain_a_life` → 16 pixels of 3'b111 at y95–98, then `lives`=3. A further `gain_a_life` at 3 → no write, `lives` stays 3.
- `lose_a_life` and `gain_a_life` asserted together in idle → no write, `lives` unchanged. A `lose_a_life` pulse during an active draw → dropped, `lives` unchanged afterwards.
- Three spaced losses → final erase at y87–90, `game_over`=1 with `active`=0 at the end edge. Later `gain_a_life`/`lose_a_life` → ignored.
- `enable` low for 5 cycles mid-erase → outputs frozen and completion delayed by exactly 5 cycles. `reset` mid-erase → INIT restarts at (146,87), `lives`=3, `game_over`=0.
